// File: rtl/multicycle_ctrl_if.sv
//==============================================================================
// Module      : multicycle_ctrl_if
// Description : Control/status bundle between the multi-cycle sequencer and
//               the RV32I datapath plus its shared memory port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instr;
    logic             mem_ready;
    logic             alu_zero;
    logic             mem_req;
    logic             mem_we;
    logic             mem_is_fetch;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             reg_write;
    logic [1:0]       wb_sel;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [3:0]       alu_op;
    logic             retired;
    logic [CNT_W-1:0] retire_cnt;
    logic             trap;
    logic             trap_timeout;

    modport master (
        input  instr, mem_ready, alu_zero,
        output mem_req, mem_we, mem_is_fetch, ir_write, pc_write, pc_src,
               reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, retired,
               retire_cnt, trap, trap_timeout
    );

    modport slave (
        output instr, mem_ready, alu_zero,
        input  mem_req, mem_we, mem_is_fetch, ir_write, pc_write, pc_src,
               reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, retired,
               retire_cnt, trap, trap_timeout
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
//==============================================================================
// Module      : multicycle_ctrl
// Description : FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I multi-cycle
//               datapath sharing one memory port; counts retired instructions.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);

    localparam int c_WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LIMIT = c_WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_LW   = 7'b0000011;
    localparam logic [6:0] c_OP_SW   = 7'b0100011;
    localparam logic [6:0] c_OP_BR   = 7'b1100011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;
    localparam logic [6:0] c_OP_JALR = 7'b1100111;

    localparam logic [3:0] c_ALU_ADD  = 4'b0010;
    localparam logic [3:0] c_ALU_SUB  = 4'b0110;
    localparam logic [3:0] c_ALU_AND  = 4'b0000;
    localparam logic [3:0] c_ALU_OR   = 4'b0001;
    localparam logic [3:0] c_ALU_XOR  = 4'b0100;
    localparam logic [3:0] c_ALU_SLL  = 4'b0101;
    localparam logic [3:0] c_ALU_SRL  = 4'b1000;
    localparam logic [3:0] c_ALU_SRA  = 4'b1001;
    localparam logic [3:0] c_ALU_SLT  = 4'b0111;
    localparam logic [3:0] c_ALU_SLTU = 4'b1010;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_WAIT_W-1:0]  r_wait;
    logic [CNT_W-1:0]     r_retire_cnt;
    logic                 r_trap;
    logic                 r_trap_timeout;

    logic                 w_mem_req;
    logic                 w_mem_we;
    logic                 w_mem_is_fetch;
    logic                 w_ir_write;
    logic                 w_pc_write;
    logic [1:0]           w_pc_src;
    logic                 w_reg_write;
    logic [1:0]           w_wb_sel;
    logic                 w_alu_src_a;
    logic [1:0]           w_alu_src_b;
    logic [3:0]           w_alu_op;
    logic                 w_retired;
    logic                 w_timeout;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_funct7b5;
    logic       w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_br, w_is_jal, w_is_jalr;
    logic       w_legal;
    logic       w_alt;
    logic [3:0] w_alu_fn;
    logic       w_br_taken;
    logic       w_wait_limit;
    logic       w_unused;

    assign w_opcode   = bus.instr[6:0];
    assign w_funct3   = bus.instr[14:12];
    assign w_funct7b5 = bus.instr[30];
    assign w_unused   = &{1'b0, bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    assign w_is_r    = (w_opcode == c_OP_R);
    assign w_is_i    = (w_opcode == c_OP_I);
    assign w_is_lw   = (w_opcode == c_OP_LW);
    assign w_is_sw   = (w_opcode == c_OP_SW);
    assign w_is_br   = (w_opcode == c_OP_BR);
    assign w_is_jal  = (w_opcode == c_OP_JAL);
    assign w_is_jalr = (w_opcode == c_OP_JALR);

    // Only BEQ (000) and BNE (001) are implemented among the branches.
    assign w_legal = w_is_r | w_is_i | w_is_lw | w_is_sw | w_is_jal | w_is_jalr |
                     (w_is_br & (w_funct3[2:1] == 2'b00));

    // funct7[5] selects sub for R-type, but for immediates only the shift-right form.
    assign w_alt = w_funct7b5 & (w_is_r | (w_funct3 == 3'b101));

    function automatic logic [3:0] f_alu_op(input logic alt, input logic [2:0] f3);
        logic [3:0] v_op;
        v_op = c_ALU_ADD;
        case (f3)
            3'b000:  v_op = alt ? c_ALU_SUB : c_ALU_ADD;
            3'b001:  v_op = c_ALU_SLL;
            3'b010:  v_op = c_ALU_SLT;
            3'b011:  v_op = c_ALU_SLTU;
            3'b100:  v_op = c_ALU_XOR;
            3'b101:  v_op = alt ? c_ALU_SRA : c_ALU_SRL;
            3'b110:  v_op = c_ALU_OR;
            default: v_op = c_ALU_AND;
        endcase
        return v_op;
    endfunction

    assign w_alu_fn     = f_alu_op(w_alt, w_funct3);
    assign w_br_taken   = (w_funct3[0] == 1'b0) ? bus.alu_zero : !bus.alu_zero;
    assign w_wait_limit = (r_wait == c_WAIT_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_wait         <= '0;
            r_retire_cnt   <= '0;
            r_trap         <= 1'b0;
            r_trap_timeout <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Any state change restarts the wait count, so FETCH/MEM always enter at zero.
            if (w_state_next != r_state) begin
                r_wait <= '0;
            end else if (((r_state == S_FETCH) || (r_state == S_MEM)) && !bus.mem_ready) begin
                r_wait <= r_wait + c_WAIT_W'(1);
            end
            if (w_retired) begin
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
            if (w_state_next == S_TRAP) begin
                r_trap <= 1'b1;
            end
            if (w_timeout) begin
                r_trap_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_is_fetch = 1'b0;
        w_ir_write     = 1'b0;
        w_pc_write     = 1'b0;
        w_pc_src       = 2'b00;
        w_reg_write    = 1'b0;
        w_wb_sel       = 2'b00;
        w_alu_src_a    = 1'b0;
        w_alu_src_b    = 2'b00;
        w_alu_op       = 4'b0000;
        w_retired      = 1'b0;
        w_timeout      = 1'b0;

        case (r_state)
            S_IDLE: w_state_next = S_FETCH;

            S_FETCH: begin
                w_mem_req      = 1'b1;
                w_mem_is_fetch = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_state_next = S_DECODE;
                end else if (w_wait_limit) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_TRAP;
                end
            end

            S_DECODE: w_state_next = w_legal ? S_EXEC : S_TRAP;

            S_EXEC: begin
                if (w_is_r) begin
                    w_alu_op     = w_alu_fn;
                    w_state_next = S_WB;
                end else if (w_is_i) begin
                    w_alu_src_b  = 2'b01;
                    w_alu_op     = w_alu_fn;
                    w_state_next = S_WB;
                end else if (w_is_lw || w_is_sw) begin
                    w_alu_src_b  = 2'b01;
                    w_alu_op     = c_ALU_ADD;
                    w_state_next = S_MEM;
                end else if (w_is_br) begin
                    w_alu_op     = c_ALU_SUB;
                    w_pc_write   = 1'b1;
                    w_pc_src     = w_br_taken ? 2'b01 : 2'b00;
                    w_retired    = 1'b1;
                    w_state_next = S_FETCH;
                end else if (w_is_jal || w_is_jalr) begin
                    w_alu_src_a  = w_is_jal;
                    w_alu_src_b  = 2'b01;
                    w_alu_op     = c_ALU_ADD;
                    w_reg_write  = 1'b1;
                    w_wb_sel     = 2'b10;
                    w_pc_write   = 1'b1;
                    w_pc_src     = 2'b10;
                    w_retired    = 1'b1;
                    w_state_next = S_FETCH;
                end else begin
                    w_state_next = S_TRAP;
                end
            end

            S_MEM: begin
                w_mem_req   = 1'b1;
                w_mem_we    = w_is_sw;
                w_alu_src_b = 2'b01;
                w_alu_op    = c_ALU_ADD;
                if (bus.mem_ready) begin
                    if (w_is_sw) begin
                        w_pc_write   = 1'b1;
                        w_retired    = 1'b1;
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_WB;
                    end
                end else if (w_wait_limit) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_TRAP;
                end
            end

            S_WB: begin
                w_reg_write  = 1'b1;
                w_wb_sel     = w_is_lw ? 2'b01 : 2'b00;
                w_pc_write   = 1'b1;
                w_retired    = 1'b1;
                w_state_next = S_FETCH;
            end

            S_TRAP: w_state_next = S_TRAP;

            default: w_state_next = S_IDLE;
        endcase
    end

    assign bus.mem_req      = w_mem_req;
    assign bus.mem_we       = w_mem_we;
    assign bus.mem_is_fetch = w_mem_is_fetch;
    assign bus.ir_write     = w_ir_write;
    assign bus.pc_write     = w_pc_write;
    assign bus.pc_src       = w_pc_src;
    assign bus.reg_write    = w_reg_write;
    assign bus.wb_sel       = w_wb_sel;
    assign bus.alu_src_a    = w_alu_src_a;
    assign bus.alu_src_b    = w_alu_src_b;
    assign bus.alu_op       = w_alu_op;
    assign bus.retired      = w_retired;
    assign bus.retire_cnt   = r_retire_cnt;
    assign bus.trap         = r_trap;
    assign bus.trap_timeout = r_trap_timeout;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
//==============================================================================
// Module      : tb_multicycle_ctrl
// Description : Directed self-checking bench for multicycle_ctrl.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(4)) bus ();

    multicycle_ctrl #(
        .MEM_TIMEOUT (15),
        .CNT_W       (4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    wire [17:0] w_obs = {bus.mem_req, bus.mem_we, bus.mem_is_fetch, bus.ir_write,
                         bus.pc_write, bus.pc_src, bus.reg_write, bus.wb_sel,
                         bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.retired};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_o(input string tag, input logic req, input logic we, input logic isf,
                         input logic irw, input logic pcw, input logic [1:0] pcs,
                         input logic rw, input logic [1:0] wbs, input logic asa,
                         input logic [1:0] asb, input logic [3:0] aop, input logic ret);
        chk(tag, {14'd0, w_obs},
            {14'd0, req, we, isf, irw, pcw, pcs, rw, wbs, asa, asb, aop, ret});
    endtask

    task automatic chk_idle(input string tag);
        chk_o(tag, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 4'b0000, 0);
    endtask

    task automatic bump();
        exp_cnt = (exp_cnt + 1) % 16;
        chk("retire_cnt", {28'd0, bus.retire_cnt}, exp_cnt);
    endtask

    // Enters at FETCH+1ns, leaves at EXEC+1ns.
    task automatic fetch_decode(input string tag, input logic [31:0] ins);
        bus.instr = ins;
        bus.mem_ready = 1'b1;
        #1;
        chk_o({tag, "/fetch"}, 1, 0, 1, 1, 0, 2'b00, 0, 2'b00, 0, 2'b00, 4'b0000, 0);
        cyc();
        bus.mem_ready = 1'b0;
        #1;
        chk_idle({tag, "/decode"});
        cyc();
    endtask

    task automatic run_alu(input string tag, input logic [31:0] ins,
                           input logic [1:0] asb, input logic [3:0] aop);
        fetch_decode(tag, ins);
        #1;
        chk_o({tag, "/exec"}, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, asb, aop, 0);
        cyc();
        #1;
        chk_o({tag, "/wb"}, 0, 0, 0, 0, 1, 2'b00, 1, 2'b00, 0, 2'b00, 4'b0000, 1);
        cyc();
        bump();
    endtask

    task automatic run_branch(input string tag, input logic [31:0] ins,
                              input logic zero, input logic [1:0] pcs);
        fetch_decode(tag, ins);
        bus.alu_zero = zero;
        #1;
        chk_o({tag, "/exec"}, 0, 0, 0, 0, 1, pcs, 0, 2'b00, 0, 2'b00, 4'b0110, 1);
        cyc();
        bus.alu_zero = 1'b0;
        bump();
    endtask

    task automatic run_jump(input string tag, input logic [31:0] ins, input logic asa);
        fetch_decode(tag, ins);
        #1;
        chk_o({tag, "/exec"}, 0, 0, 0, 0, 1, 2'b10, 1, 2'b10, asa, 2'b01, 4'b0010, 1);
        cyc();
        bump();
    endtask

    // Enters at any +1ns point, leaves at FETCH+1ns after a clean restart.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        bus.mem_ready = 1'b0;
        bus.alu_zero = 1'b0;
        exp_cnt = 0;
        #1;
        chk_idle({tag, "/in_reset"});
        chk({tag, "/cnt"}, {28'd0, bus.retire_cnt}, 32'd0);
        chk({tag, "/trap"}, {31'd0, bus.trap}, 32'd0);
        chk({tag, "/trap_to"}, {31'd0, bus.trap_timeout}, 32'd0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk_idle({tag, "/idle"});
        cyc();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.instr = 32'd0;
        bus.mem_ready = 1'b0;
        bus.alu_zero = 1'b0;
        repeat (2) cyc();
        do_reset("por");

        run_alu("add", 32'h002081B3, 2'b00, 4'b0010);

        // lw with two wait cycles in MEM
        fetch_decode("lw", 32'h0080A283);
        #1;
        chk_o("lw/exec", 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b01, 4'b0010, 0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = (i == 2);
            #1;
            chk_o("lw/mem", 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b01, 4'b0010, 0);
            cyc();
        end
        bus.mem_ready = 1'b0;
        #1;
        chk_o("lw/wb", 0, 0, 0, 0, 1, 2'b00, 1, 2'b01, 0, 2'b00, 4'b0000, 1);
        cyc();
        bump();

        fetch_decode("sw", 32'h0020A223);
        #1;
        chk_o("sw/exec", 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b01, 4'b0010, 0);
        cyc();
        bus.mem_ready = 1'b1;
        #1;
        chk_o("sw/mem", 1, 1, 0, 0, 1, 2'b00, 0, 2'b00, 0, 2'b01, 4'b0010, 1);
        cyc();
        bus.mem_ready = 1'b0;
        bump();

        run_branch("beq_z1", 32'h00208063, 1'b1, 2'b01);
        run_branch("beq_z0", 32'h00208063, 1'b0, 2'b00);
        run_branch("bne_z1", 32'h00209063, 1'b1, 2'b00);
        run_branch("bne_z0", 32'h00209063, 1'b0, 2'b01);

        run_jump("jal", 32'h000000EF, 1'b1);
        run_jump("jalr", 32'h00008067, 1'b0);

        run_alu("srai", 32'h4030D293, 2'b01, 4'b1001);
        run_alu("addi_neg", 32'hC0008093, 2'b01, 4'b0010);
        run_alu("sltu", 32'h0020B1B3, 2'b00, 4'b1010);
        run_alu("sub", 32'h402081B3, 2'b00, 4'b0110);
        run_alu("and", 32'h0020F1B3, 2'b00, 4'b0000);
        run_alu("slli", 32'h00309293, 2'b01, 4'b0101);
        run_alu("or", 32'h0020E1B3, 2'b00, 4'b0001);
        chk("wrap", {28'd0, bus.retire_cnt}, 32'd0);

        // Fetch ready arrives in the 15th request cycle: no trap.
        bus.instr = 32'h00208063;
        for (int i = 0; i < 14; i++) begin
            #1;
            chk("limit/wait_req", {31'd0, bus.mem_req}, 32'd1);
            cyc();
        end
        bus.mem_ready = 1'b1;
        #1;
        chk_o("limit/fetch", 1, 0, 1, 1, 0, 2'b00, 0, 2'b00, 0, 2'b00, 4'b0000, 0);
        cyc();
        bus.mem_ready = 1'b0;
        #1;
        chk_idle("limit/decode");
        chk("limit/trap", {31'd0, bus.trap}, 32'd0);
        cyc();
        cyc();
        bump();

        // Reset while a load is waiting in MEM.
        fetch_decode("lw_rst", 32'h0080A283);
        cyc();
        #1;
        chk("lw_rst/mem_req", {31'd0, bus.mem_req}, 32'd1);
        cyc();
        do_reset("mid_mem");

        fetch_decode("ecall", 32'h00000073);
        #1;
        chk("ecall/trap", {31'd0, bus.trap}, 32'd1);
        chk("ecall/trap_to", {31'd0, bus.trap_timeout}, 32'd0);
        chk_idle("ecall/strobes");
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = 1'b1;
            bus.alu_zero = 1'b1;
            cyc();
            #1;
            chk_idle("ecall/hold");
            chk("ecall/hold_trap", {31'd0, bus.trap}, 32'd1);
        end
        do_reset("after_ecall");

        fetch_decode("bad_br", 32'h0020A063);
        #1;
        chk("bad_br/trap", {31'd0, bus.trap}, 32'd1);
        do_reset("after_bad_br");

        // Fetch never answered: trap after 15 request cycles.
        bus.instr = 32'h002081B3;
        for (int i = 0; i < 14; i++) cyc();
        #1;
        chk("to/req15", {31'd0, bus.mem_req}, 32'd1);
        chk("to/trap15", {31'd0, bus.trap}, 32'd0);
        cyc();
        #1;
        chk("to/trap", {31'd0, bus.trap}, 32'd1);
        chk("to/trap_to", {31'd0, bus.trap_timeout}, 32'd1);
        chk_idle("to/strobes");
        do_reset("after_to");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
